// File: rtl/mm_result_reader.sv
`default_nettype none
// ============================================================================
// Module  : mm_result_reader
// Brief   : Reads NUM_SLOTS two-half results from the matrix engine and
//           presents each reassembled result through a valid/ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module mm_result_reader #(
  parameter int NUM_SLOTS = 16,
  parameter int RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mm_finish,
  output logic        mm_read,
  output logic [4:0]  mm_ram_slot,
  input  logic [8:0]  mm_out_data,
  output logic [17:0] res_data,
  output logic [4:0]  res_slot,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_CAP_LO  = 3'd3,
    S_CAP_HI  = 3'd4,
    S_PRESENT = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS - 1);
  localparam logic [2:0] WAIT_LAST = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  wait_q;
  logic [8:0]  lo_q;
  logic        finish_q;
  logic        armed_q;
  logic        mm_read_q;
  logic [4:0]  mm_ram_slot_q;
  logic [17:0] res_data_q;
  logic [4:0]  res_slot_q;
  logic        res_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        finish_rise;

  // armed_q blocks a start until mm_finish has been seen low after reset
  assign finish_rise = mm_finish & ~finish_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 5'd0;
      wait_q        <= 3'd0;
      lo_q          <= 9'd0;
      finish_q      <= 1'b0;
      armed_q       <= 1'b0;
      mm_read_q     <= 1'b0;
      mm_ram_slot_q <= 5'd0;
      res_data_q    <= 18'd0;
      res_slot_q    <= 5'd0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      finish_q  <= mm_finish;
      mm_read_q <= 1'b0;
      done_q    <= 1'b0;
      if (!mm_finish) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (finish_rise) begin
            state_q       <= S_REQ;
            cnt_q         <= 5'd0;
            mm_read_q     <= 1'b1;
            mm_ram_slot_q <= 5'd0;
            busy_q        <= 1'b1;
          end
        end
        S_REQ: begin
          wait_q  <= 3'd0;
          state_q <= (RD_LAT == 1) ? S_CAP_LO : S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) state_q <= S_CAP_LO;
          else                     wait_q  <= wait_q + 3'd1;
        end
        S_CAP_LO: begin
          lo_q    <= mm_out_data;
          state_q <= S_CAP_HI;
        end
        S_CAP_HI: begin
          res_data_q  <= {mm_out_data, lo_q};
          res_slot_q  <= cnt_q;
          res_valid_q <= 1'b1;
          state_q     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (cnt_q == LAST_SLOT) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q         <= cnt_q + 5'd1;
              mm_read_q     <= 1'b1;
              mm_ram_slot_q <= cnt_q + 5'd1;
              state_q       <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign mm_read     = mm_read_q;
  assign mm_ram_slot = mm_ram_slot_q;
  assign res_data    = res_data_q;
  assign res_slot    = res_slot_q;
  assign res_valid   = res_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mm_result_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_mm_result_reader
// Brief   : Scoreboard bench for mm_result_reader across several slot-count and
//           read-latency configurations, each driven by its own engine model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mm_result_reader;

  localparam int NI = 5;

  function automatic int ns_of(input int i);
    case (i)
      3:       return 1;
      4:       return 32;
      default: return 4;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      1:       return 1;
      2:       return 7;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [8:0] enc_lo(input int i, input logic [4:0] s);
    return (i == 0) ? 9'h0AA : {4'h3, s};
  endfunction

  function automatic logic [8:0] enc_hi(input int i, input logic [4:0] s);
    return (i == 0) ? 9'h155 : {4'hC, s};
  endfunction

  logic        clk;
  logic        rst_a   [NI];
  logic        fin_a   [NI];
  logic        rdy_a   [NI];
  logic        rd_a    [NI];
  logic        val_a   [NI];
  logic        busy_a  [NI];
  logic        done_a  [NI];
  logic [4:0]  slot_a  [NI];
  logic [4:0]  rslot_a [NI];
  logic [8:0]  od_a    [NI];
  logic [17:0] rdat_a  [NI];
  logic [5:0]  hist    [NI][8];

  int n_checks;
  int n_errors;
  int cyc;
  int exp_rd [NI], last_rd [NI], last_acc [NI], res_pass [NI];
  int passes [NI], dones [NI], reads [NI];
  logic prev_busy [NI], prev_val [NI], prev_done [NI], hold [NI];
  logic [17:0] hold_dat [NI];
  logic [4:0]  hold_slot [NI], last_rslot [NI];
  logic [25:0] sb_q [$];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mm_result_reader #(
      .NUM_SLOTS(ns_of(gi)),
      .RD_LAT   (lat_of(gi))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_a[gi]),
      .mm_finish  (fin_a[gi]),
      .mm_read    (rd_a[gi]),
      .mm_ram_slot(slot_a[gi]),
      .mm_out_data(od_a[gi]),
      .res_data   (rdat_a[gi]),
      .res_slot   (rslot_a[gi]),
      .res_valid  (val_a[gi]),
      .res_ready  (rdy_a[gi]),
      .busy       (busy_a[gi]),
      .done       (done_a[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Engine model: lower half RD_LAT cycles after the read, upper half one later
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        hist[i][0] <= {rd_a[i], slot_a[i]};
        for (int k = 1; k < 8; k++) hist[i][k] <= hist[i][k-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      od_a[i] = 9'h1FF;
      if (hist[i][lat_of(i)-1][5] === 1'b1)
        od_a[i] = enc_lo(i, hist[i][lat_of(i)-1][4:0]);
      else if (hist[i][lat_of(i)][5] === 1'b1)
        od_a[i] = enc_hi(i, hist[i][lat_of(i)][4:0]);
    end
  end

  // Monitor and scoreboard
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_a[i]) begin
          prev_busy[i] = 1'b0;
          prev_val[i]  = 1'b0;
          prev_done[i] = 1'b0;
          hold[i]      = 1'b0;
          sb_q.delete();
        end else begin
          if (busy_a[i] && !prev_busy[i]) begin
            passes[i]++;
            exp_rd[i]   = 0;
            res_pass[i] = 0;
          end
          if (rd_a[i]) begin
            check("rd_busy", busy_a[i], 1);
            check("rd_while_valid", val_a[i], 0);
            check("rd_slot", slot_a[i], exp_rd[i]);
            check("rd_in_range", exp_rd[i] < ns_of(i), 1);
            if (exp_rd[i] != 0) check("rd_after_accept", cyc - last_acc[i], 1);
            sb_q.push_back({3'(i), 5'(exp_rd[i]), enc_hi(i, 5'(exp_rd[i])), enc_lo(i, 5'(exp_rd[i]))});
            exp_rd[i]++;
            last_rd[i] = cyc;
            reads[i]++;
          end
          if (val_a[i] && !prev_val[i])
            check("present_latency", cyc - last_rd[i], lat_of(i) + 2);
          if (hold[i]) begin
            check("hold_valid", val_a[i], 1);
            check("hold_data", rdat_a[i], hold_dat[i]);
            check("hold_slot", rslot_a[i], hold_slot[i]);
          end
          if (val_a[i] && rdy_a[i]) begin
            if (sb_q.size() == 0) begin
              check("sb_empty", 1, 0);
            end else begin
              e = sb_q.pop_front();
              check("res_data", rdat_a[i], e[17:0]);
              check("res_slot", rslot_a[i], e[22:18]);
              check("res_inst", i, e[25:23]);
            end
            res_pass[i]++;
            last_acc[i]   = cyc;
            last_rslot[i] = rslot_a[i];
          end
          hold[i]      = val_a[i] && !rdy_a[i];
          hold_dat[i]  = rdat_a[i];
          hold_slot[i] = rslot_a[i];
          if (done_a[i]) begin
            dones[i]++;
            check("done_single", prev_done[i], 0);
            check("done_after_accept", cyc - last_acc[i], 1);
            check("done_result_count", res_pass[i], ns_of(i));
            check("done_last_slot", last_rslot[i], ns_of(i) - 1);
            check("done_busy", busy_a[i], 1);
          end
          prev_busy[i] = busy_a[i];
          prev_val[i]  = val_a[i];
          prev_done[i] = done_a[i];
        end
      end
    end
  end

  task automatic zero_outs(input int i);
    check("z_mm_read", rd_a[i], 0);
    check("z_mm_ram_slot", slot_a[i], 0);
    check("z_res_data", rdat_a[i], 0);
    check("z_res_slot", rslot_a[i], 0);
    check("z_res_valid", val_a[i], 0);
    check("z_busy", busy_a[i], 0);
    check("z_done", done_a[i], 0);
  endtask

  task automatic wait_rd(input int i, input logic [4:0] s);
    bit found = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      #1;
      found = rd_a[i] && (slot_a[i] == s);
    end
    if (!found) check("rd_timeout", 0, 1);
  endtask

  task automatic wait_val(input int i);
    bit found = 0;
    for (int n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      #1;
      found = val_a[i];
    end
    if (!found) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int i);
    int d0 = dones[i];
    bit found = 0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(posedge clk);
      found = (dones[i] != d0);
    end
    if (!found) check("done_timeout", 0, 1);
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1 fin_a[i] = 1'b1;
    @(posedge clk); #1 fin_a[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst_a[i] = 1'b0;
      fin_a[i] = 1'b0;
      rdy_a[i] = 1'b1;
    end
    #23;
    for (int i = 0; i < NI; i++) zero_outs(i);
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) rst_a[i] = 1'b1;
    repeat (3) @(posedge clk);

    // Nominal four-slot pass
    pulse_start(0);
    wait_done(0);
    repeat (10) @(posedge clk);
    check("nominal_dones", dones[0], 1);
    check("nominal_reads", reads[0], 4);

    // Backpressure on slot 1
    pulse_start(0);
    wait_rd(0, 5'd1);
    @(posedge clk); #1 rdy_a[0] = 1'b0;
    wait_val(0);
    repeat (10) @(posedge clk);
    #1 rdy_a[0] = 1'b1;
    wait_done(0);
    repeat (10) @(posedge clk);
    check("bp_dones", dones[0], 2);

    // Level-high finish plus a second edge mid-pass
    @(posedge clk); #1 fin_a[0] = 1'b1;
    wait_rd(0, 5'd1);
    @(posedge clk); #1 fin_a[0] = 1'b0;
    @(posedge clk); #1 fin_a[0] = 1'b1;
    wait_done(0);
    repeat (30) @(posedge clk);
    check("spur_passes", passes[0], 3);
    check("spur_dones", dones[0], 3);
    check("spur_idle", busy_a[0], 0);

    // Reset during slot 2 WAIT, released with finish high
    @(posedge clk); #1 fin_a[0] = 1'b0;
    @(posedge clk); #1 fin_a[0] = 1'b1;
    wait_rd(0, 5'd2);
    @(posedge clk); #2 rst_a[0] = 1'b0;
    #1 zero_outs(0);
    repeat (3) @(posedge clk);
    #1 rst_a[0] = 1'b1;
    repeat (20) @(posedge clk);
    check("rst_level_no_start", busy_a[0], 0);
    check("rst_passes", passes[0], 4);
    check("rst_no_done", dones[0], 3);
    #1 fin_a[0] = 1'b0;
    @(posedge clk); #1 fin_a[0] = 1'b1;
    wait_done(0);
    repeat (10) @(posedge clk);
    check("restart_passes", passes[0], 5);
    check("restart_dones", dones[0], 4);
    check("inst0_reads", reads[0], 19);
    #1 fin_a[0] = 1'b0;

    // Latency and slot-count boundaries
    for (int i = 1; i < NI; i++) begin
      pulse_start(i);
      wait_done(i);
      repeat (20) @(posedge clk);
      check("cfg_dones", dones[i], 1);
      check("cfg_reads", reads[i], ns_of(i));
      check("cfg_idle", busy_a[i], 0);
    end

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
